// File: rtl/rc_cascade_scan.sv
// Extends a 4-bit counter to 16 bits by counting its ripple-carry edges, and
// scans the four hex digits onto a common-anode 7-segment display.
module rc_cascade_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Qa,
  input  logic        Qb,
  input  logic        Qc,
  input  logic        Qd,
  input  logic        Rc,
  output logic [15:0] total,
  output logic        ovf,
  output logic [3:0]  AN,
  output logic [7:0]  SEGMENT
);

  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  logic [11:0]   hi_cnt_q, hi_cnt_d;
  logic          rc_q, rc_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    scan_idx_q, scan_idx_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    digit_s;

  // Active-low segment pattern {dp,g,f,e,d,c,b,a}, dp kept off.
  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0:    pat = 8'hC0;
      4'h1:    pat = 8'hF9;
      4'h2:    pat = 8'hA4;
      4'h3:    pat = 8'hB0;
      4'h4:    pat = 8'h99;
      4'h5:    pat = 8'h92;
      4'h6:    pat = 8'h82;
      4'h7:    pat = 8'hF8;
      4'h8:    pat = 8'h80;
      4'h9:    pat = 8'h90;
      4'hA:    pat = 8'h88;
      4'hB:    pat = 8'h83;
      4'hC:    pat = 8'hC6;
      4'hD:    pat = 8'hA1;
      4'hE:    pat = 8'h86;
      4'hF:    pat = 8'h8E;
      default: pat = 8'hFF;
    endcase
    return pat;
  endfunction

  assign total = {hi_cnt_q, Qd, Qc, Qb, Qa};

  // Carry-edge counting and wrap detection; ovf is sticky until reset.
  always_comb begin
    hi_cnt_d = hi_cnt_q;
    ovf_d    = ovf_q;
    rc_d     = Rc;
    if (Rc && !rc_q) begin
      hi_cnt_d = hi_cnt_q + 12'd1;
      if (hi_cnt_q == 12'hFFF) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end else begin
      hi_cnt_d = hi_cnt_q;
    end
  end

  // Prescaler and digit selection; scan advances on the prescaler's last count.
  always_comb begin
    pre_d      = pre_q;
    scan_idx_d = scan_idx_q;
    if (pre_q == PRE_MAX) begin
      pre_d      = '0;
      scan_idx_d = scan_idx_q + 2'd1;
    end else begin
      pre_d      = pre_q + {{(PW-1){1'b0}}, 1'b1};
      scan_idx_d = scan_idx_q;
    end
  end

  // Digit enable and segments both come from the current scan_idx so they stay paired.
  always_comb begin
    digit_s = 4'h0;
    case (scan_idx_q)
      2'd0:    digit_s = total[3:0];
      2'd1:    digit_s = total[7:4];
      2'd2:    digit_s = total[11:8];
      2'd3:    digit_s = total[15:12];
      default: digit_s = 4'h0;
    endcase
    an_d  = ~(4'b0001 << scan_idx_q);
    seg_d = seg_decode(digit_s);
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_cnt_q   <= 12'd0;
      rc_q       <= 1'b0;
      ovf_q      <= 1'b0;
      pre_q      <= '0;
      scan_idx_q <= 2'd0;
      an_q       <= 4'b1111;
      seg_q      <= 8'hFF;
    end else begin
      hi_cnt_q   <= hi_cnt_d;
      rc_q       <= rc_d;
      ovf_q      <= ovf_d;
      pre_q      <= pre_d;
      scan_idx_q <= scan_idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign ovf     = ovf_q;
  assign AN      = an_q;
  assign SEGMENT = seg_q;

endmodule

// File: tb/tb_rc_cascade_scan.sv
// Randomised and directed bench for rc_cascade_scan with an edge-counting
// reference model checked on every falling edge.
module tb_rc_cascade_scan;

  localparam int unsigned DIV = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  q;
  logic        rc;
  logic [15:0] total;
  logic        ovf;
  logic [3:0]  an;
  logic [7:0]  seg;

  int errors = 0;
  int checks = 0;

  localparam logic [7:0] DEC [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  rc_cascade_scan #(.SCAN_DIV(DIV)) dut (
    .clk(clk), .rst(rst),
    .Qa(q[0]), .Qb(q[1]), .Qc(q[2]), .Qd(q[3]), .Rc(rc),
    .total(total), .ovf(ovf), .AN(an), .SEGMENT(seg)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: count carry rising edges, derive digit from cycles since reset.
  int          m_hi;
  bit          m_prev_rc;
  bit          m_ovf;
  int          m_cyc;
  bit          m_known = 1'b0;
  logic [3:0]  m_an;
  logic [7:0]  m_seg;

  always @(posedge clk) begin
    int idx;
    int tot;
    if (rst) begin
      m_hi = 0; m_prev_rc = 1'b0; m_ovf = 1'b0; m_cyc = 0;
      m_an = 4'hF; m_seg = 8'hFF; m_known = 1'b1;
    end else if (m_known) begin
      idx   = (m_cyc / DIV) % 4;
      tot   = m_hi * 16 + int'(q);
      m_an  = 4'(~(1 << idx));
      m_seg = DEC[(tot >> (4 * idx)) & 15];
      if (rc && !m_prev_rc) begin
        if (m_hi == 4095) m_ovf = 1'b1;
        m_hi = (m_hi + 1) % 4096;
      end
      m_prev_rc = rc;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("total", 32'(total), 32'(m_hi * 16 + int'(q)));
      chk("ovf",   32'(ovf),   32'(m_ovf));
      chk("AN",    32'(an),    32'(m_an));
      chk("SEG",   32'(seg),   32'(m_seg));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse();
    rc = 1'b1; step();
    rc = 1'b0; step();
  endtask

  task automatic do_reset();
    rst = 1'b1; rc = 1'b0; step();
    rst = 1'b0;
  endtask

  logic [3:0] prev_an;
  logic [3:0] exp_an4 [4];
  logic [7:0] exp_seg4 [4];
  logic [11:0] hi_before;
  bit found;

  initial begin
    exp_an4  = '{4'hE, 4'hD, 4'hB, 4'h7};
    exp_seg4 = '{8'h8E, 8'hA4, 8'h88, 8'hF9};

    // Reset with digit 5 on the counter, then first displayed digit.
    rst = 1'b1; q = 4'h5; rc = 1'b0;
    step(); step();
    chk("rst_AN", 32'(an), 32'h0000000F);
    chk("rst_SEG", 32'(seg), 32'h000000FF);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_total", 32'(total), 32'h00000005);
    rst = 1'b0;
    step();
    chk("first_AN", 32'(an), 32'h0000000E);
    chk("first_SEG", 32'(seg), 32'h00000092);

    // 20 full counts of an attached 4-bit counter.
    do_reset();
    for (int i = 0; i < 320; i++) begin
      q = 4'(i % 16); rc = ((i % 16) == 15); step();
    end
    chk("count20", 32'(total[15:4]), 32'h014);

    // Held Rc levels count once each.
    hi_before = total[15:4];
    q = 4'h0; rc = 1'b0; step();
    rc = 1'b1; repeat (5) step();
    rc = 1'b0; repeat (3) step();
    rc = 1'b1; step();
    rc = 1'b0; step();
    chk("held_rc", 32'(total[15:4] - hi_before), 32'h2);

    // Preload 0x1A2 then hold 1A2F and watch the scan.
    do_reset();
    for (int i = 0; i < 12'h1A1; i++) pulse();
    q = 4'hF; rc = 1'b1; step();
    chk("preload_1A2F", 32'(total), 32'h00001A2F);
    found = 1'b0;
    prev_an = an;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (prev_an == 4'h7 && an == 4'hE) found = 1'b1;
      prev_an = an;
    end
    chk("scan_sync", 32'(found), 32'h1);
    for (int k = 0; k < 32; k++) begin
      chk("scan_AN", 32'(an), 32'(exp_an4[(k % 16) / 4]));
      chk("scan_SEG", 32'(seg), 32'(exp_seg4[(k % 16) / 4]));
      step();
    end

    // Wrap of the upper field sets the sticky flag.
    do_reset();
    q = 4'h0;
    for (int i = 0; i < 4095; i++) pulse();
    chk("pre_wrap_hi", 32'(total[15:4]), 32'hFFF);
    chk("pre_wrap_ovf", 32'(ovf), 32'h0);
    pulse();
    chk("wrap_hi", 32'(total[15:4]), 32'h000);
    chk("wrap_ovf", 32'(ovf), 32'h1);
    pulse(); pulse();
    chk("ovf_sticky", 32'(ovf), 32'h1);
    chk("post_wrap_hi", 32'(total[15:4]), 32'h002);
    do_reset();
    chk("ovf_cleared", 32'(ovf), 32'h0);

    // Reset colliding with a carry edge while digit 2 is selected.
    pulse(); pulse(); pulse();
    found = 1'b0;
    prev_an = an;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (prev_an != 4'hB && an == 4'hB) found = 1'b1;
      prev_an = an;
    end
    chk("idx2_sync", 32'(found), 32'h1);
    rst = 1'b1; rc = 1'b1; step();
    chk("rst_wins_hi", 32'(total[15:4]), 32'h000);
    chk("rst_wins_AN", 32'(an), 32'h0000000F);
    rst = 1'b0; rc = 1'b0; step();
    chk("rst_wins_after", 32'(total[15:4]), 32'h000);
    chk("rst_wins_AN2", 32'(an), 32'h0000000E);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      q   = 4'($urandom);
      rc  = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
